// File: rtl/param_data_array.sv
// Block-organised word array with CPU read/write port and a sequential block-fill engine.
// Optional even parity per word when DATA_PARITY_EN is defined; otherwise parity_err is tied 0.
module param_data_array #(
  parameter int NUM_BLOCKS      = 128,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int WORD_W          = 16,
  localparam int BW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1,
  localparam int WW = $clog2(WORDS_PER_BLOCK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [BW-1:0]     rd_blk,
  input  logic [WW-1:0]     rd_word,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [BW-1:0]     wr_blk,
  input  logic [WW-1:0]     wr_word,
  input  logic [WORD_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              fill_start,
  input  logic [BW-1:0]     fill_blk,
  input  logic              fill_valid,
  input  logic [WORD_W-1:0] fill_data,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              parity_err
);

  // state | meaning
  // IDLE  | no fill active, fill_start accepted
  // FILL  | writing fill words into the latched block, counter tracks word
  // DONE  | fill_done pulse cycle, returns to IDLE

  localparam int AW    = BW + WW;
  localparam int DEPTH = NUM_BLOCKS * WORDS_PER_BLOCK;
`ifdef DATA_PARITY_EN
  localparam int SW = WORD_W + 1;
`else
  localparam int SW = WORD_W;
`endif

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t            state_q;
  logic [WW-1:0]     cnt_q;
  logic [BW-1:0]     fill_blk_q;
  logic              fill_busy_q;
  logic              fill_done_q;
  logic [SW-1:0]     mem_q [DEPTH];
  logic [WORD_W-1:0] rd_data_q;
  logic              rd_valid_q;

  logic              fill_wr;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [SW-1:0]     mem_wdata;
  logic [SW-1:0]     rd_sel;

  function automatic logic blk_in_range(input logic [BW-1:0] b);
    return ({1'b0, b} < (BW+1)'(NUM_BLOCKS));
  endfunction

  function automatic logic [SW-1:0] encode(input logic [WORD_W-1:0] d);
`ifdef DATA_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  assign fill_wr = (state_q == FILL) && fill_valid;
  // Reset forces the ack low so no write appears accepted while storage is held clear.
  assign wr_ack  = rst && wr_en && !fill_wr;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (fill_wr) begin
      mem_we    = blk_in_range(fill_blk_q);
      mem_waddr = {fill_blk_q, cnt_q};
      mem_wdata = encode(fill_data);
    end else if (wr_ack) begin
      mem_we    = blk_in_range(wr_blk);
      mem_waddr = {wr_blk, wr_word};
      mem_wdata = encode(wr_data);
    end
  end

  always_comb begin
    rd_sel = '0;
    if (blk_in_range(rd_blk)) rd_sel = mem_q[{rd_blk, rd_word}];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= rd_sel[WORD_W-1:0];
    end
  end

`ifdef DATA_PARITY_EN
  logic perr_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) perr_q <= 1'b0;
    else      perr_q <= rd_en && (^rd_sel);
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fill_blk_q  <= '0;
      fill_busy_q <= 1'b0;
      fill_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          fill_done_q <= 1'b0;
          if (fill_start) begin
            state_q     <= FILL;
            fill_blk_q  <= fill_blk;
            cnt_q       <= '0;
            fill_busy_q <= 1'b1;
          end
        end
        FILL: begin
          if (fill_valid) begin
            if (cnt_q == WW'(WORDS_PER_BLOCK - 1)) begin
              state_q     <= DONE;
              cnt_q       <= '0;
              fill_busy_q <= 1'b0;
              fill_done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          fill_done_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          fill_busy_q <= 1'b0;
          fill_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign fill_busy = fill_busy_q;
  assign fill_done = fill_done_q;

endmodule

// File: tb/tb_param_data_array.sv
// Scoreboard bench for param_data_array: a driver updates a 2-D array model and queues
// expected reads and fill_done pulses; a negedge monitor pops and compares them.
module tb_param_data_array;
  localparam int NB = 128;
  localparam int WPB = 8;
  localparam int W = 16;
  localparam int BW = 7;
  localparam int WW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rd_en = 1'b0;
  logic [BW-1:0] rd_blk = '0;
  logic [WW-1:0] rd_word = '0;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic          wr_en = 1'b0;
  logic [BW-1:0] wr_blk = '0;
  logic [WW-1:0] wr_word = '0;
  logic [W-1:0]  wr_data = '0;
  logic          wr_ack;
  logic          fill_start = 1'b0;
  logic [BW-1:0] fill_blk = '0;
  logic          fill_valid = 1'b0;
  logic [W-1:0]  fill_data = '0;
  logic          fill_busy;
  logic          fill_done;
  logic          parity_err;

  param_data_array #(.NUM_BLOCKS(NB), .WORDS_PER_BLOCK(WPB), .WORD_W(W)) dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rd_blk(rd_blk), .rd_word(rd_word), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_blk(wr_blk), .wr_word(wr_word), .wr_data(wr_data), .wr_ack(wr_ack),
    .fill_start(fill_start), .fill_blk(fill_blk), .fill_valid(fill_valid), .fill_data(fill_data),
    .fill_busy(fill_busy), .fill_done(fill_done), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; logic [W-1:0] d; logic pe;} rd_exp_t;

  logic [W-1:0] model [NB][WPB];
  logic         corrupt [NB][WPB];
  rd_exp_t      rq[$];
  int           dq[$];
  int           cyc = 0;
  bit           m_active = 0;
  bit           m_done = 0;
  int           m_cnt = 0;
  int           m_blk = 0;
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int b = 0; b < NB; b++)
      for (int w = 0; w < WPB; w++) begin
        model[b][w] = '0;
        corrupt[b][w] = 1'b0;
      end
    m_active = 0; m_done = 0; m_cnt = 0;
    rq.delete(); dq.delete();
  endtask

  // Inputs are already set (at a negedge); check the combinational ack, then apply one edge.
  task automatic step();
    logic exp_ack;
    bit was_active, was_done;
    exp_ack = wr_en && !(m_active && fill_valid);
    #1;
    chk("wr_ack", wr_ack, exp_ack);
    @(posedge clk);
    cyc++;
    was_active = m_active;
    was_done = m_done;
    if (rd_en) rq.push_back('{cyc, model[rd_blk][rd_word], corrupt[rd_blk][rd_word]});
    if (was_active && fill_valid) begin
      model[m_blk][m_cnt] = fill_data;
      corrupt[m_blk][m_cnt] = 1'b0;
      if (m_cnt == WPB - 1) begin
        m_active = 0; m_done = 1; dq.push_back(cyc);
      end else m_cnt++;
    end else if (exp_ack) begin
      model[wr_blk][wr_word] = wr_data;
      corrupt[wr_blk][wr_word] = 1'b0;
    end
    if (was_done) m_done = 0;
    if (!was_active && !was_done && fill_start) begin
      m_active = 1; m_cnt = 0; m_blk = int'(fill_blk);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rd_en = 0; wr_en = 0; fill_start = 0; fill_valid = 0;
  endtask

  task automatic do_write(input int b, input int w, input logic [W-1:0] d);
    idle_inputs();
    wr_en = 1; wr_blk = BW'(b); wr_word = WW'(w); wr_data = d;
    step();
    wr_en = 0;
  endtask

  task automatic do_read(input int b, input int w);
    idle_inputs();
    rd_en = 1; rd_blk = BW'(b); rd_word = WW'(w);
    step();
    rd_en = 0;
  endtask

  // Monitor: registered outputs compared against queued expectations once per cycle.
  logic [W-1:0] hold = '0;
  always @(negedge clk) begin
    rd_exp_t e;
    bit exp_done;
    if (!rst) begin
      hold = '0;
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_fill_busy", fill_busy, 0);
      chk("rst_fill_done", fill_done, 0);
      chk("rst_parity_err", parity_err, 0);
    end else begin
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        e = rq.pop_front();
        chk("rd_valid", rd_valid, 1);
        chk("rd_data", rd_data, e.d);
        chk("parity_err", parity_err, e.pe);
        hold = e.d;
      end else begin
        chk("rd_valid_idle", rd_valid, 0);
        chk("rd_data_hold", rd_data, hold);
        chk("parity_err_idle", parity_err, 0);
      end
      exp_done = (dq.size() > 0 && dq[0] == cyc);
      if (exp_done) void'(dq.pop_front());
      chk("fill_done", fill_done, exp_done);
      chk("fill_busy", fill_busy, m_active);
    end
  end

  initial begin
    clear_model();
    // Reset with write request held to see the ack forced low.
    wr_en = 1;
    #2;
    chk("rst_wr_ack", wr_ack, 0);
    repeat (2) @(negedge clk);
    wr_en = 0;
    rst = 1;
    step();

    // Single write then read.
    do_write(5, 3, 16'hBEEF);
    do_read(5, 3);
    step();

    // Fill blk 10 with a gap after word 3, a colliding CPU write and an ignored fill_start.
    idle_inputs();
    fill_start = 1; fill_blk = 7'd10;
    step();
    fill_start = 0;
    for (int w = 0; w < WPB; w++) begin
      fill_valid = 1; fill_data = W'(16'h1000 + w);
      if (w == 2) begin
        wr_en = 1; wr_blk = 7'd10; wr_word = 3'd2; wr_data = 16'hDEAD;
      end
      if (w == 5) begin
        fill_start = 1; fill_blk = 7'd20;
      end
      step();
      idle_inputs();
      if (w == 3) repeat (2) step();
    end
    repeat (2) step();
    for (int w = 0; w < WPB; w++) do_read(10, w);
    step();

    // Same-cycle read and write of the same address returns old data.
    idle_inputs();
    rd_en = 1; rd_blk = 7'd1; rd_word = 3'd0;
    wr_en = 1; wr_blk = 7'd1; wr_word = 3'd0; wr_data = 16'h5555;
    step();
    idle_inputs();
    do_read(1, 0);
    step();

    // Randomised traffic concentrated on a few blocks.
    for (int i = 0; i < 600; i++) begin
      rd_en      = ($urandom_range(0, 1) == 1);
      rd_blk     = BW'($urandom_range(0, 3));
      rd_word    = WW'($urandom);
      wr_en      = ($urandom_range(0, 2) == 0);
      wr_blk     = BW'($urandom_range(0, 3));
      wr_word    = WW'($urandom);
      wr_data    = W'($urandom);
      fill_start = ($urandom_range(0, 15) == 0);
      fill_blk   = BW'($urandom_range(0, 3));
      fill_valid = ($urandom_range(0, 1) == 1);
      fill_data  = W'($urandom);
      step();
    end
    idle_inputs();
    repeat (3) step();

    // Reset in the middle of a fill.
    fill_start = 1; fill_blk = 7'd10;
    step();
    fill_start = 0;
    for (int w = 0; w < 4; w++) begin
      fill_valid = 1; fill_data = W'(16'h2000 + w);
      step();
    end
    fill_valid = 1; fill_start = 1; fill_blk = 7'd20;
    #2;
    rst = 0;
    #1;
    chk("midfill_busy", fill_busy, 0);
    chk("midfill_done", fill_done, 0);
    chk("midfill_rd_valid", rd_valid, 0);
    clear_model();
    @(negedge clk);
    @(negedge clk);
    idle_inputs();
    rst = 1;
    fill_valid = 1; fill_data = 16'hFFFF;
    repeat (3) step();
    idle_inputs();
    for (int w = 0; w < WPB; w++) do_read(10, w);
    do_read(5, 3);
    do_read(1, 0);
    step();

`ifdef DATA_PARITY_EN
    do_write(3, 1, 16'h00F0);
    dut.mem_q[3*WPB + 1] = dut.mem_q[3*WPB + 1] ^ 17'h1;
    model[3][1] = model[3][1] ^ 16'h1;
    corrupt[3][1] = 1'b1;
    do_read(3, 1);
    do_write(3, 2, 16'h0F0F);
    do_read(3, 2);
    step();
`endif

    chk("rd_queue_drained", rq.size(), 0);
    chk("done_queue_drained", dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
